neuron_mac: RTL and testbench

- Sequential multiply-accumulate stage for one neuron, directly upstream of the activation-function stage.
- Consumes N_TERMS signed input/weight pairs over a valid/ready handshake and accumulates their products into a saturating signed 12-bit sum.
- Presents the sum on a held valid/ready output, which the activation stage consumes. That stage takes the sign bit and bits [6:3].

---
 rtl/neuron_mac.sv | 104 ++++++++++
 tb/tb_neuron_mac.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate for one neuron: N_TERMS signed x*w products summed
// into a saturating signed accumulator, result held on a valid/ready output.
module neuron_mac #(
    parameter int N_TERMS = 4,
    parameter int DW      = 5,
    parameter int AW      = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] w_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [AW-1:0] sum_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int CW = $clog2(N_TERMS) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N_TERMS - 1);
    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic signed [AW-1:0]  sum_q, sum_d;
    logic [CW-1:0]         count_q, count_d;

    logic signed [2*DW-1:0] prod;
    logic signed [AW:0]     acc_wide;
    logic signed [AW-1:0]   acc_sat;

    // One guard bit above the accumulator: overflow shows up as the top two bits differing.
    always_comb begin
        prod     = x_in * w_in;
        acc_wide = {acc_q[AW-1], acc_q} + {{(AW+1-2*DW){prod[2*DW-1]}}, prod};
        if (acc_wide[AW] != acc_wide[AW-1]) begin
            acc_sat = acc_wide[AW] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sat = acc_wide[AW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_d   = acc_sat;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_IDX) begin
                        sum_d   = acc_sat;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A start coinciding with the output handshake skips the IDLE cycle.
                if (out_ready) begin
                    state_d = IDLE;
                    if (start) begin
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ACC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum_out   = sum_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac: a 4-term instance for the handshake
// scenarios and a 16-term instance for saturation.
module tb_neuron_mac;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic signed [4:0] x_in;
    logic signed [4:0] w_in;
    logic              in_valid;
    logic              out_ready;

    logic signed [11:0] sum4, sum16;
    logic               ir4, ov4, busy4;
    logic               ir16, ov16, busy16;

    int n_checks = 0;
    int n_fail   = 0;
    int xs[16];
    int ws[16];

    neuron_mac #(.N_TERMS(4), .DW(5), .AW(12)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .w_in(w_in),
        .in_valid(in_valid), .in_ready(ir4), .sum_out(sum4), .out_valid(ov4),
        .out_ready(out_ready), .busy(busy4)
    );

    neuron_mac #(.N_TERMS(16), .DW(5), .AW(12)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .w_in(w_in),
        .in_valid(in_valid), .in_ready(ir16), .sum_out(sum16), .out_valid(ov16),
        .out_ready(out_ready), .busy(busy16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int cur_ov(input bit big);
        return big ? int'(ov16) : int'(ov4);
    endfunction
    function automatic int cur_busy(input bit big);
        return big ? int'(busy16) : int'(busy4);
    endfunction
    function automatic int cur_ir(input bit big);
        return big ? int'(ir16) : int'(ir4);
    endfunction
    function automatic int cur_sum(input bit big);
        return big ? int'(sum16) : int'(sum4);
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Feeds xs/ws[0..n-1]; gap_len idle cycles are inserted before term gap_at.
    // Latency is counted in clock edges from the edge that samples start.
    task automatic run_acc(input string tag, input bit big, input int n,
                           input int gap_at, input int gap_len, input bit start_in_gap,
                           input bit do_start, input bit release_out,
                           input int exp_sum, input int exp_lat);
        int ti   = 0;
        int gaps = gap_len;
        int lat  = 0;
        out_ready = release_out;
        if (do_start) begin
            @(negedge clk);
            start    = 1'b1;
            in_valid = 1'b0;
        end
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 1) begin
                check({tag, "_busy_acc"}, cur_busy(big), 1);
                check({tag, "_in_ready_acc"}, cur_ir(big), 1);
            end
            if (cur_ov(big) != 0) begin
                lat = cyc;
                break;
            end
            if (ti == gap_at && gaps > 0) begin
                in_valid = 1'b0;
                start    = start_in_gap;
                gaps--;
            end else if (ti < n) begin
                in_valid = 1'b1;
                x_in     = 5'(xs[ti]);
                w_in     = 5'(ws[ti]);
                ti++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_sum"}, cur_sum(big), exp_sum);
        $display("txn %s: sum_out=%0d latency=%0d", tag, cur_sum(big), lat);
        if (release_out) begin
            @(negedge clk);
            check({tag, "_out_valid_drop"}, cur_ov(big), 0);
            check({tag, "_busy_idle"}, cur_busy(big), 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x_in      = '0;
        w_in      = '0;
        #3;
        check("rst_sum", int'(sum4), 0);
        check("rst_out_valid", int'(ov4), 0);
        check("rst_in_ready", int'(ir4), 0);
        check("rst_busy", int'(busy4), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic 4-term dot product: 5+12+21+32
        for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ws[i] = i + 5; end
        run_acc("basic", 1'b0, 4, 99, 0, 1'b0, 1'b1, 1'b1, 70, 5);

        // Stalled input: two idle cycles between the second and third terms
        for (int i = 0; i < 4; i++) begin xs[i] = -16; ws[i] = 15; end
        run_acc("stall", 1'b0, 4, 2, 2, 1'b0, 1'b1, 1'b1, -960, 7);

        // Positive clamp on the 16-term instance
        do_reset();
        for (int i = 0; i < 16; i++) begin xs[i] = -16; ws[i] = -16; end
        run_acc("sat_pos", 1'b1, 16, 99, 0, 1'b0, 1'b1, 1'b1, 2047, 17);
        for (int i = 0; i < 16; i++) begin xs[i] = -16; ws[i] = 15; end
        run_acc("sat_neg", 1'b1, 16, 99, 0, 1'b0, 1'b1, 1'b1, -2048, 17);
        // Clamp at 2047 after 8 terms, then 4 x -240 pull it back: 2047-960
        for (int i = 0; i < 16; i++) begin xs[i] = -16; ws[i] = (i < 12) ? -16 : 15; end
        run_acc("sat_recover", 1'b1, 16, 99, 0, 1'b0, 1'b1, 1'b1, 1087, 17);

        // Back-pressure in DONE: 21-32-30+18
        do_reset();
        xs[0] = 7;  ws[0] = 3;
        xs[1] = -8; ws[1] = 4;
        xs[2] = 5;  ws[2] = -6;
        xs[3] = 2;  ws[3] = 9;
        run_acc("hold", 1'b0, 4, 99, 0, 1'b0, 1'b1, 1'b0, -23, 5);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("hold_out_valid", int'(ov4), 1);
            check("hold_in_ready", int'(ir4), 0);
            check("hold_sum", int'(sum4), -23);
            start    = k[0];
            in_valid = ~in_valid;
            x_in     = 5'(k);
            w_in     = 5'(-k);
        end
        @(negedge clk);
        check("hold_sum_final", int'(sum4), -23);
        start     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin xs[i] = 2; ws[i] = 3; end
        run_acc("back2back", 1'b0, 4, 99, 0, 1'b0, 1'b0, 1'b1, 24, 5);

        // Asynchronous reset mid-accumulation, checked between clock edges
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        x_in     = 5'sd1;
        w_in     = 5'sd1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sum", int'(sum4), 0);
        check("arst_out_valid", int'(ov4), 0);
        check("arst_in_ready", int'(ir4), 0);
        check("arst_busy", int'(busy4), 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin xs[i] = 1; ws[i] = 1; end
        run_acc("after_arst", 1'b0, 4, 99, 0, 1'b0, 1'b1, 1'b1, 4, 5);

        // in_valid ignored in IDLE, start ignored in ACC
        do_reset();
        in_valid = 1'b1;
        x_in     = 5'sd7;
        w_in     = 5'sd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_busy", int'(busy4), 0);
            check("idle_in_ready", int'(ir4), 0);
        end
        for (int i = 0; i < 4; i++) begin xs[i] = i + 1; ws[i] = 1; end
        run_acc("ignore_start", 1'b0, 4, 2, 1, 1'b1, 1'b1, 1'b1, 10, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
